// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one downstream APB slave port between NB_REQ requesters.
// Replays each granted request as a clean SETUP/ACCESS pair; a PREADY timeout ends hung transfers with an error.
//
// state  | meaning
// IDLE   | no transfer; picks the next requester after rr_ptr
// SETUP  | psel=1, penable=0 for one cycle
// ACCESS | psel=1, penable=1, waiting for pready or timeout
// DONE   | one-cycle req_pready strobe to the granted requester
module apb_req_arbiter #(
  parameter int NB_REQ         = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NB_REQ-1:0]                req_psel,
  input  logic [NB_REQ-1:0]                req_penable,
  input  logic [NB_REQ-1:0]                req_pwrite,
  input  logic [NB_REQ*APB_ADDR_WIDTH-1:0] req_paddr,
  input  logic [NB_REQ*APB_DATA_WIDTH-1:0] req_pwdata,
  output logic [APB_DATA_WIDTH-1:0]        req_prdata,
  output logic [NB_REQ-1:0]                req_pready,
  output logic                             req_pslverr,
  output logic                             psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [APB_ADDR_WIDTH-1:0]        paddr,
  output logic [APB_DATA_WIDTH-1:0]        pwdata,
  input  logic [APB_DATA_WIDTH-1:0]        prdata,
  input  logic                             pready,
  input  logic                             pslverr,
  output logic [7:0]                       timeout_cnt
);

  localparam int PW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt;
  logic [TW-1:0] timer;
  logic [PW-1:0] arb_idx;
  logic          arb_found;

  // Scan from farthest to nearest so the first requester after rr_ptr is the last one written.
  always_comb begin : arb_comb
    int cand;
    arb_idx   = '0;
    arb_found = 1'b0;
    cand      = 0;
    for (int i = NB_REQ; i >= 1; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NB_REQ) cand = cand - NB_REQ;
      if (req_psel[cand]) begin
        arb_idx   = PW'(cand);
        arb_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= PW'(NB_REQ - 1);
      gnt         <= '0;
      timer       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      req_prdata  <= '0;
      req_pslverr <= 1'b0;
      req_pready  <= '0;
      timeout_cnt <= '0;
    end else begin
      req_pready <= '0;
      case (state)
        S_IDLE: begin
          if (arb_found) begin
            gnt    <= arb_idx;
            rr_ptr <= arb_idx;
            pwrite <= req_pwrite[arb_idx];
            paddr  <= req_paddr[int'(arb_idx)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            pwdata <= req_pwdata[int'(arb_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            psel   <= 1'b1;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          timer <= timer + 1'b1;
          if (pready) begin
            req_prdata      <= prdata;
            req_pslverr     <= pslverr;
            req_pready[gnt] <= 1'b1;
            psel            <= 1'b0;
            penable         <= 1'b0;
            state           <= S_DONE;
          end else if (TIMEOUT_CYCLES != 0 && timer == TIMER_LAST) begin
            // Hung slave: complete with an error so the requester is never stalled forever.
            req_prdata      <= '0;
            req_pslverr     <= 1'b1;
            req_pready[gnt] <= 1'b1;
            psel            <= 1'b0;
            penable         <= 1'b0;
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            state           <= S_DONE;
          end
        end
        S_DONE: begin
          timer <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^req_penable;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: expected responses are queued when a request is driven
// and popped when a req_pready strobe appears.
module tb_apb_req_arbiter;

  localparam int NB = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NB-1:0]   req_psel = '0;
  logic [NB-1:0]   req_penable = '0;
  logic [NB-1:0]   req_pwrite = '0;
  logic [NB*AW-1:0] req_paddr = '0;
  logic [NB*DW-1:0] req_pwdata = '0;
  logic [DW-1:0]   req_prdata;
  logic [NB-1:0]   req_pready;
  logic            req_pslverr;
  logic            psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;
  logic [7:0]      timeout_cnt;

  apb_req_arbiter #(
    .NB_REQ(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_psel(req_psel), .req_penable(req_penable), .req_pwrite(req_pwrite),
    .req_paddr(req_paddr), .req_pwdata(req_pwdata),
    .req_prdata(req_prdata), .req_pready(req_pready), .req_pslverr(req_pslverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  // Slave model: pready after slv_wait extra ACCESS cycles (negative = never), data derived from address
  int          slv_wait = 0;
  logic [31:0] slv_xor = '0;
  logic        slv_err = 1'b0;
  int          acc_cnt = 0;

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign pready  = psel && penable && (slv_wait >= 0) && (acc_cnt == slv_wait);
  assign prdata  = paddr ^ slv_xor;
  assign pslverr = slv_err;

  int checks = 0;
  int failures = 0;

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [NB-1:0] gnt;
    logic [31:0]   rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_done = 0;
  int   acc_len = 0;
  int   last_acc_len = 0;

  always @(negedge clk) begin
    if (penable) acc_len++;
    else if (acc_len != 0) begin
      last_acc_len = acc_len;
      acc_len = 0;
    end
    if (req_pready != '0) begin
      n_done++;
      if (sb.size() == 0) check_val("sb_unexpected", 32'(req_pready), 32'd0);
      else begin
        mon_e = sb.pop_front();
        check_val("sb_gnt", 32'(req_pready), 32'(mon_e.gnt));
        check_val("sb_rdata", req_prdata, mon_e.rdata);
        check_val("sb_err", 32'(req_pslverr), 32'(mon_e.err));
      end
    end
  end

  task automatic wait_done(int target, int budget);
    int c = 0;
    while (n_done < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    check_val("done_timeout", n_done, target);
  endtask

  task automatic drive_req(int idx, logic wr, logic [31:0] addr, logic [31:0] wdata);
    req_psel[idx]           = 1'b1;
    req_pwrite[idx]         = wr;
    req_paddr[idx*AW +: AW]  = addr;
    req_pwdata[idx*DW +: DW] = wdata;
  endtask

  // Uncontended transfer with pready in the first ACCESS cycle; checks cycle-exact timing.
  task automatic single_xfer(string tag, int idx, logic wr, logic [31:0] addr,
                             logic [31:0] wdata, logic [31:0] exp_rd, logic exp_err);
    logic [NB-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    sb.push_back('{oh, exp_rd, exp_err});
    @(posedge clk); #1;
    drive_req(idx, wr, addr, wdata);
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "_setup"}, {30'd0, psel, penable}, 32'b10);
    @(negedge clk);
    check_val({tag, "_access"}, {30'd0, psel, penable}, 32'b11);
    check_val({tag, "_paddr"}, paddr, addr);
    check_val({tag, "_pwrite"}, 32'(pwrite), 32'(wr));
    @(negedge clk);
    check_val({tag, "_strobe"}, 32'(req_pready), 32'(oh));
    @(posedge clk); #1;
    req_psel[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int base;
    int c;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_psel_pen", {30'd0, psel, penable}, 32'd0);
    check_val("rst_req_pready", 32'(req_pready), 32'd0);
    check_val("rst_prdata", req_prdata, 32'd0);
    check_val("rst_misc", {23'd0, req_pslverr, timeout_cnt}, 32'd0);
    check_val("rst_paddr", paddr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // simultaneous requests right after reset: requester 0 first, then strict alternation
    slv_wait = 0;
    slv_xor  = 32'h0;
    sb.push_back('{2'b01, 32'h1A10_0010, 1'b0});
    sb.push_back('{2'b10, 32'h1A10_0020, 1'b0});
    sb.push_back('{2'b01, 32'h1A10_0010, 1'b0});
    sb.push_back('{2'b10, 32'h1A10_0020, 1'b0});
    base = n_done;
    drive_req(0, 1'b0, 32'h1A10_0010, 32'h0);
    drive_req(1, 1'b0, 32'h1A10_0020, 32'h0);
    wait_done(base + 4, 60);
    req_psel = '0;

    // single read with exact latency
    slv_xor = 32'h1A10_1000 ^ 32'hCAFE_0001;
    single_xfer("t1", 0, 1'b0, 32'h1A10_1000, 32'h0, 32'hCAFE_0001, 1'b0);

    // write by req1 with a slave that waits three cycles
    slv_wait = 3;
    sb.push_back('{2'b10, 32'h1A10_3000 ^ slv_xor, 1'b0});
    @(posedge clk); #1;
    drive_req(1, 1'b1, 32'h1A10_3000, 32'h5A5A_5A5A);
    @(posedge clk);
    @(negedge clk);
    check_val("t3_setup", {30'd0, psel, penable}, 32'b10);
    repeat (4) begin
      @(negedge clk);
      check_val("t3_penable", 32'(penable), 32'd1);
      check_val("t3_pwdata", pwdata, 32'h5A5A_5A5A);
    end
    @(negedge clk);
    check_val("t3_strobe", 32'(req_pready), 32'b10);
    @(posedge clk); #1;
    req_psel[1] = 1'b0;
    @(negedge clk);
    check_val("t3_strobe_once", 32'(req_pready), 32'd0);
    check_val("t3_access_len", last_acc_len, 4);

    // hung slave: forced error after 8 ACCESS cycles
    slv_wait = -1;
    sb.push_back('{2'b01, 32'h0, 1'b1});
    base = n_done;
    @(posedge clk); #1;
    drive_req(0, 1'b0, 32'h1A10_4000, 32'h0);
    wait_done(base + 1, 40);
    req_psel[0] = 1'b0;
    check_val("t4_access_len", last_acc_len, 8);
    check_val("t4_timeout_cnt", 32'(timeout_cnt), 32'd1);
    slv_wait = 0;
    single_xfer("t4_next", 1, 1'b0, 32'h1A10_5000, 32'h0, 32'h1A10_5000 ^ slv_xor, 1'b0);

    // slave error passed through, not counted as timeout
    slv_err = 1'b1;
    single_xfer("t5", 0, 1'b0, 32'h1A10_6000, 32'h0, 32'h1A10_6000 ^ slv_xor, 1'b1);
    slv_err = 1'b0;
    check_val("t5_timeout_cnt", 32'(timeout_cnt), 32'd1);

    // reset in the middle of ACCESS abandons the transfer
    slv_wait = -1;
    @(posedge clk); #1;
    drive_req(0, 1'b0, 32'h1A10_7000, 32'h0);
    c = 0;
    while (!penable && c < 20) begin
      @(negedge clk);
      c++;
    end
    check_val("t6_reach_access", 32'(penable), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("t6_async_drop", {29'd0, psel, penable, |req_pready}, 32'd0);
    req_psel = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("t6_timeout_cnt", 32'(timeout_cnt), 32'd0);
    slv_wait = 0;
    sb.push_back('{2'b01, 32'h1A10_8000 ^ slv_xor, 1'b0});
    sb.push_back('{2'b10, 32'h1A10_9000 ^ slv_xor, 1'b0});
    base = n_done;
    drive_req(0, 1'b0, 32'h1A10_8000, 32'h0);
    drive_req(1, 1'b0, 32'h1A10_9000, 32'h0);
    wait_done(base + 2, 30);
    req_psel = '0;
    single_xfer("t6_req1", 1, 1'b1, 32'h1A10_A000, 32'h1234_5678, 32'h1A10_A000 ^ slv_xor, 1'b0);

    repeat (3) @(posedge clk);
    check_val("sb_left", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
